// File: rtl/breakout_pkg.sv
// Shared Breakout constants, ball sequencing state and saturating helper.
package breakout_pkg;

  localparam int COORD_W       = 11;
  localparam int SCR_X_MAX     = 639;
  localparam int SCR_Y_MAX     = 479;
  localparam int BALL_SIZE_DEF = 8;
  localparam int PADDLE_Y_DEF  = 450;

  // Block field geometry used by the column modules
  localparam int BLOCK_W    = 64;
  localparam int BLOCK_H    = 16;
  localparam int BLOCK_COLS = 10;
  localparam int BLOCK_ROWS = 5;
  localparam int BLOCK_TOP  = 48;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2,
    ST_OVER  = 2'd3
  } ball_state_t;

  // Unsigned subtraction clamped at zero so coordinates never wrap
  function automatic logic [COORD_W-1:0] sat_sub(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/breakout_ball_axis.sv
// One motion axis of the ball: pending bounce latches, direction
// resolution with wall/override priority and saturating position step.
module breakout_ball_axis
  import breakout_pkg::*;
#(
  parameter int          SPEED     = 2,
  parameter int          SIZE      = 8,
  parameter int          POS_MAX   = 632,
  parameter bit          HI_WALL   = 1'b1,
  parameter int          HI_LIMIT  = 637,
  parameter logic [10:0] SERVE_POS = 11'd316,
  parameter bit          SERVE_DIR = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               active,
  input  logic               restore,
  input  logic               move_lo,
  input  logic               move_hi,
  input  logic               force_lo,
  output logic [COORD_W-1:0] pos,
  output logic [COORD_W-1:0] pos_next,
  output logic               dir
);

  localparam logic [COORD_W-1:0] SPD   = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] SZ_M1 = COORD_W'(SIZE - 1);
  localparam logic [COORD_W-1:0] HI_C  = COORD_W'(HI_LIMIT);
  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(POS_MAX);
  localparam logic [COORD_W:0]   MAX_W = (COORD_W+1)'(POS_MAX);

  logic             pend_lo, pend_hi;
  logic             eff_lo, eff_hi;
  logic             dir_res;
  logic [COORD_W:0] up;

  // A request on the tick cycle itself still counts for that tick
  assign eff_lo = active & (pend_lo | move_lo);
  assign eff_hi = active & (pend_hi | move_hi);

  // Pending requests accumulate between ticks, only while in play
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_lo <= 1'b0;
      pend_hi <= 1'b0;
    end else if (!active || tick) begin
      pend_lo <= 1'b0;
      pend_hi <= 1'b0;
    end else begin
      pend_lo <= pend_lo | move_lo;
      pend_hi <= pend_hi | move_hi;
    end
  end

  // Direction: block requests, then low/high walls, then external override
  always_comb begin
    dir_res = dir;
    if (eff_lo && eff_hi) dir_res = ~dir;
    else if (eff_hi)      dir_res = 1'b1;
    else if (eff_lo)      dir_res = 1'b0;
    if (pos <= SPD) dir_res = 1'b1;
    if (HI_WALL && ((pos + SZ_M1) >= HI_C)) dir_res = 1'b0;
    if (force_lo) dir_res = 1'b0;
  end

  // Position step clamped to [0, POS_MAX]
  always_comb begin
    up = {1'b0, pos} + {1'b0, SPD};
    if (dir_res) pos_next = (up > MAX_W) ? MAX_C : up[COORD_W-1:0];
    else         pos_next = sat_sub(pos, SPD);
  end

  // Position and direction advance only on a tick while in play
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= SERVE_POS;
      dir <= SERVE_DIR;
    end else if (restore) begin
      pos <= SERVE_POS;
      dir <= SERVE_DIR;
    end else if (tick && active) begin
      pos <= pos_next;
      dir <= dir_res;
    end
  end

endmodule

// File: rtl/breakout_ball_ctrl.sv
// Ball motion controller: serve/play/miss/over sequencing, lives count,
// paddle bounce and miss detection around two axis units.
module breakout_ball_ctrl
  import breakout_pkg::*;
#(
  parameter int BALL_SIZE = breakout_pkg::BALL_SIZE_DEF,
  parameter int X_MAX     = breakout_pkg::SCR_X_MAX,
  parameter int Y_MAX     = breakout_pkg::SCR_Y_MAX,
  parameter int SPEED     = 2,
  parameter int PADDLE_Y  = breakout_pkg::PADDLE_Y_DEF,
  parameter int SERVE_X   = 316,
  parameter int SERVE_Y   = 300,
  parameter int LIVES     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               moveU,
  input  logic               moveD,
  input  logic               moveL,
  input  logic               moveR,
  input  logic [COORD_W-1:0] paddle_x_l,
  input  logic [COORD_W-1:0] paddle_x_r,
  input  logic               launch,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] ball_x_l,
  output logic [COORD_W-1:0] ball_x_r,
  output logic [COORD_W-1:0] ball_y_t,
  output logic [COORD_W-1:0] ball_y_b,
  output logic               ball_ON,
  output logic [1:0]         lives,
  output logic               life_lost,
  output logic               game_over
);

  localparam logic [COORD_W-1:0] SZ_M1  = COORD_W'(BALL_SIZE - 1);
  localparam logic [COORD_W-1:0] SPD    = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] PAD_Y  = COORD_W'(PADDLE_Y);
  localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(Y_MAX);

  ball_state_t        state, state_next;
  logic               launch_lat;
  logic               restore, lose, active, paddle_hit;
  logic               dir_x, dir_y;
  logic [COORD_W-1:0] x_next, y_next;
  logic               unused_axis;

  assign active = (state == ST_PLAY);

  assign paddle_hit = (ball_y_b >= sat_sub(PAD_Y, SPD)) && (ball_y_b <= PAD_Y) &&
                      (ball_x_r >= paddle_x_l) && (ball_x_l <= paddle_x_r);

  breakout_ball_axis #(
    .SPEED(SPEED), .SIZE(BALL_SIZE), .POS_MAX(X_MAX - BALL_SIZE + 1),
    .HI_WALL(1'b1), .HI_LIMIT(X_MAX - SPEED),
    .SERVE_POS(COORD_W'(SERVE_X)), .SERVE_DIR(1'b1)
  ) u_axis_x (
    .clk(clk), .reset(reset), .tick(frame_tick), .active(active),
    .restore(restore), .move_lo(moveL), .move_hi(moveR), .force_lo(1'b0),
    .pos(ball_x_l), .pos_next(x_next), .dir(dir_x)
  );

  breakout_ball_axis #(
    .SPEED(SPEED), .SIZE(BALL_SIZE), .POS_MAX((1 << COORD_W) - BALL_SIZE),
    .HI_WALL(1'b0), .HI_LIMIT(0),
    .SERVE_POS(COORD_W'(SERVE_Y)), .SERVE_DIR(1'b0)
  ) u_axis_y (
    .clk(clk), .reset(reset), .tick(frame_tick), .active(active),
    .restore(restore), .move_lo(moveU), .move_hi(moveD), .force_lo(paddle_hit),
    .pos(ball_y_t), .pos_next(y_next), .dir(dir_y)
  );

  // Horizontal next position and both directions are internal to the axes
  assign unused_axis = ^{x_next, dir_x, dir_y};

  assign ball_x_r  = ball_x_l + SZ_M1;
  assign ball_y_b  = ball_y_t + SZ_M1;
  assign game_over = (state == ST_OVER);

  // Ball pixel hit, suppressed once the game is over
  always_comb begin
    ball_ON = (pix_x >= ball_x_l) && (pix_x <= ball_x_r) &&
              (pix_y >= ball_y_t) && (pix_y <= ball_y_b) && (state != ST_OVER);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_SERVE;
    else       state <= state_next;
  end

  // Next state: every transition happens on a frame tick
  always_comb begin
    state_next = state;
    restore    = 1'b0;
    lose       = 1'b0;
    if (frame_tick) begin
      unique case (state)
        ST_SERVE: if (launch_lat || launch) state_next = ST_PLAY;
        ST_PLAY:  if ((y_next + SZ_M1) >= YMAX_C) state_next = ST_MISS;
        ST_MISS: begin
          lose = 1'b1;
          if (lives == 2'd1) begin
            state_next = ST_OVER;
          end else begin
            state_next = ST_SERVE;
            restore    = 1'b1;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Launch request held until the serve tick consumes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                launch_lat <= 1'b0;
    else if (state != ST_SERVE || frame_tick) launch_lat <= 1'b0;
    else if (launch)                          launch_lat <= 1'b1;
  end

  // Lives count and one-cycle loss pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lives     <= 2'(LIVES);
      life_lost <= 1'b0;
    end else begin
      life_lost <= lose;
      if (lose) lives <= lives - 2'd1;
    end
  end

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// Directed bench for breakout_ball_ctrl: frame vector table plus
// hand sequences for walls, paddle, misses, game over and async reset.
module tb_breakout_ball_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        moveU = 1'b0, moveD = 1'b0, moveL = 1'b0, moveR = 1'b0;
  logic [10:0] paddle_x_l = 11'd1000, paddle_x_r = 11'd1100;
  logic        launch = 1'b0;
  logic [10:0] pix_x = 11'd0, pix_y = 11'd0;
  logic [10:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
  logic        ball_ON;
  logic [1:0]  lives;
  logic        life_lost, game_over;

  int passed = 0;
  int total  = 0;

  breakout_ball_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .moveU(moveU), .moveD(moveD), .moveL(moveL), .moveR(moveR),
    .paddle_x_l(paddle_x_l), .paddle_x_r(paddle_x_r), .launch(launch),
    .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
    .ball_ON(ball_ON), .lives(lives), .life_lost(life_lost), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit l, mu, md, ml, mr, ot;
    int ex, ey, el;
  } vec_t;

  vec_t tbl[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_ball(input string name, input int x, input int y);
    check({name, ".x_l"}, int'(ball_x_l), x);
    check({name, ".x_r"}, int'(ball_x_r), x + 7);
    check({name, ".y_t"}, int'(ball_y_t), y);
    check({name, ".y_b"}, int'(ball_y_b), y + 7);
  endtask

  task automatic set_moves(input bit mu, input bit md, input bit ml, input bit mr);
    moveU = mu; moveD = md; moveL = ml; moveR = mr;
  endtask

  // One frame: 12 idle cycles (optional move pulse 10 cycles before tick), then tick
  task automatic frame(input bit l, input bit mu, input bit md, input bit ml,
                       input bit mr, input bit on_tick);
    launch = l;
    for (int i = 0; i < 12; i++) begin
      if (!on_tick && i == 2) set_moves(mu, md, ml, mr);
      else set_moves(1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    frame_tick = 1'b1;
    if (on_tick) set_moves(mu, md, ml, mr);
    step();
    frame_tick = 1'b0;
    set_moves(1'b0, 1'b0, 1'b0, 1'b0);
    launch = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 316, 300, 3};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 318, 298, 3};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 320, 296, 3};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 322, 294, 3};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 324, 292, 3};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 326, 294, 3};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 328, 296, 3};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 330, 294, 3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 328, 292, 3};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 330, 290, 3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 332, 292, 3};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 334, 294, 3};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 336, 292, 3};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 334, 290, 3};

    // Reset state
    step(); step();
    reset = 1'b0;
    step();
    check_ball("reset", 316, 300);
    check("reset.lives", int'(lives), 3);
    check("reset.game_over", int'(game_over), 0);
    check("reset.life_lost", int'(life_lost), 0);
    pix_x = 11'd316; pix_y = 11'd300; #1 check("on.corner_tl", int'(ball_ON), 1);
    pix_x = 11'd323; pix_y = 11'd307; #1 check("on.corner_br", int'(ball_ON), 1);
    pix_x = 11'd324; pix_y = 11'd300; #1 check("on.right_out", int'(ball_ON), 0);
    pix_x = 11'd315; pix_y = 11'd300; #1 check("on.left_out", int'(ball_ON), 0);

    // Serve hold: no launch, move requests ignored
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("serve_hold", 316, 300);
    check("serve_hold.lives", int'(lives), 3);

    // Launch, free flight and block bounces
    for (int i = 0; i < 14; i++) begin
      frame(tbl[i].l, tbl[i].mu, tbl[i].md, tbl[i].ml, tbl[i].mr, tbl[i].ot);
      check($sformatf("vec%0d.x", i), int'(ball_x_l), tbl[i].ex);
      check($sformatf("vec%0d.y", i), int'(ball_y_t), tbl[i].ey);
      check($sformatf("vec%0d.lives", i), int'(lives), tbl[i].el);
    end

    // Left wall: travel left to x_l=2 while y bounces, then wall forces dx=+
    for (int j = 0; j < 166; j++)
      frame(1'b0, (j % 2) == 1, (j % 2) == 0, 1'b0, 1'b0, 1'b0);
    check_ball("at_left_wall", 2, 290);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("left_wall_bounce", 4, 288);

    // Paddle: descend to y_b=449, then paddle under the ball sends it up
    for (int k = 0; k < 77; k++)
      frame(1'b0, 1'b0, k == 0, 1'b0, 1'b0, 1'b0);
    check_ball("above_paddle", 158, 442);
    paddle_x_l = 11'd100; paddle_x_r = 11'd200;
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("paddle_bounce", 160, 440);

    // First miss
    paddle_x_l = 11'd1000; paddle_x_r = 11'd1100;
    for (int k = 0; k < 16; k++)
      frame(1'b0, 1'b0, k == 0, 1'b0, 1'b0, 1'b0);
    check_ball("miss1_enter", 192, 472);
    check("miss1_enter.lives", int'(lives), 3);
    frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("miss1.life_lost", int'(life_lost), 1);
    check("miss1.lives", int'(lives), 2);
    check_ball("miss1_restore", 316, 300);
    step();
    check("miss1.life_lost_pulse", int'(life_lost), 0);

    // Remaining lives: latched launch pulse, then fall past the bottom
    for (int life = 1; life >= 0; life--) begin
      launch = 1'b1; step(); launch = 1'b0;
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_ball($sformatf("launch_l%0d", life), 316, 300);
      for (int k = 0; k < 86; k++)
        frame(1'b0, 1'b0, k == 0, 1'b0, 1'b0, 1'b0);
      check_ball($sformatf("fall_l%0d", life), 488, 472);
      pix_x = 11'd490; pix_y = 11'd475;
      #1 check($sformatf("miss_on_l%0d", life), int'(ball_ON), 1);
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("miss_lost_l%0d", life), int'(life_lost), 1);
      check($sformatf("miss_lives_l%0d", life), int'(lives), life);
      check($sformatf("miss_over_l%0d", life), int'(game_over), (life == 0) ? 1 : 0);
    end
    check_ball("over_frozen", 488, 472);
    check("over.ball_on", int'(ball_ON), 0);
    frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("over_hold", 488, 472);
    check("over_hold.game_over", int'(game_over), 1);
    check("over_hold.life_lost", int'(life_lost), 0);

    // Reset out of OVER, then async reset mid-play with a pending request
    reset = 1'b1; step(); reset = 1'b0;
    check("over_reset.game_over", int'(game_over), 0);
    check("over_reset.lives", int'(lives), 3);
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("play_again", 320, 296);
    moveL = 1'b1; step(); moveL = 1'b0;
    #3 reset = 1'b1;
    #1;
    check_ball("async_reset", 316, 300);
    check("async_reset.lives", int'(lives), 3);
    check("async_reset.game_over", int'(game_over), 0);
    step(); step();
    reset = 1'b0;
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("after_reset_move", 318, 298);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/breakout_ball_ctrl.md
# breakout_ball_ctrl

Ball motion controller for the Breakout datapath. Consumes the registered bounce requests (moveU/moveD/moveL/moveR) from the block-column modules, ORed across all columns. Also consumes paddle position and a per-frame tick. Produces the ball bounding-box coordinates that every block column and the pixel mixer read, and owns the serve / play / miss / game-over sequencing and the lives count.

## Interface

Parameters:
- BALL_SIZE, 8, ball edge length in pixels
- X_MAX, 639, rightmost visible pixel column
- Y_MAX, 479, bottom visible pixel row
- SPEED, 2, pixels moved per axis per frame
- PADDLE_Y, 450, paddle top row
- SERVE_X, 316, ball_x_l at serve
- SERVE_Y, 300, ball_y_t at serve
- LIVES, 3, lives at reset (max 3)

Ports:
- clk  in  1  system pixel clock; single clock domain
- reset  in  1  asynchronous, active-high; clears all state
- frame_tick  in  1  one-cycle pulse per frame, end of visible area
- moveU, moveD, moveL, moveR  in  1 each  bounce requests, ORed over all columns
- paddle_x_l, paddle_x_r  in  11  paddle horizontal extent
- launch  in  1  serve button, level, synchronous
- pix_x, pix_y  in  11  current scan pixel
- ball_x_l, ball_x_r, ball_y_t, ball_y_b  out  11  ball bounding box
- ball_ON  out  1  combinational: pixel inside box and state != OVER
- lives  out  2  remaining lives
- life_lost  out  1  one-cycle pulse on life decrement
- game_over  out  1  high in OVER

## Operation

- **States:** SERVE, PLAY, MISS, OVER.
- **Reset values:** SERVE; ball_x_l=316, ball_y_t=300, so x_r=323 and y_b=307; dx=+, dy=−(up); lives=3; life_lost=0; game_over=0; pending flags clear.
- **Derived edges:** ball_x_r = ball_x_l+BALL_SIZE−1 and ball_y_b = ball_y_t+BALL_SIZE−1, both from registers.
- **Pending flags:**
  - pendU/D/L/R set on any cycle the matching move* is high.
  - A move* high on the tick cycle itself counts for that tick.
  - Cleared on every frame_tick and held clear outside PLAY.
- **SERVE:**
  - Ball is held at the serve position.
  - launch high on any cycle sets a launch latch; the next frame_tick enters PLAY with dx=+ and dy=−.
- **PLAY, on frame_tick, direction is resolved in this order; later steps override earlier:**
  1. X from pending flags: L&R → invert dx; R only → +; L only → −.
  2. Y from pending flags: U&D → invert dy; D only → + (down); U only → −.
  3. Walls:
     - ball_x_l ≤ SPEED → dx=+.
     - ball_x_r ≥ X_MAX−SPEED → dx=−.
     - ball_y_t ≤ SPEED → dy=+.
  4. Paddle: ball_y_b in [PADDLE_Y−SPEED, PADDLE_Y] and ball_x_r ≥ paddle_x_l and ball_x_l ≤ paddle_x_r → dy=−.
  5. Move each axis by ±SPEED using the resolved direction.
  6. Saturate ball_x_l to [0, X_MAX−BALL_SIZE+1] and ball_y_t to ≥0.
  7. If the new ball_y_b ≥ Y_MAX, go to MISS.
- **MISS:**
  - Ball frozen.
  - Next frame_tick: lives−1 and life_lost pulse.
  - If the new lives is 0, go to OVER. Otherwise go to SERVE with serve position and dirs restored.
- **OVER:** game_over=1, ball frozen, ball_ON=0. Exits only via reset.
- **Ignored inputs:**
  - launch outside SERVE.
  - move* outside PLAY.
- **Arithmetic:** 11-bit unsigned. Subtraction is saturated at 0 before compare, so there is no wrap below 0.

## Timing

- Position, direction, state and lives change only on a frame_tick cycle. New values are visible the cycle after the tick.
- move* arrive one cycle after the columns sample the ball. The pending latch makes a request issued up to the tick cycle count for that tick.
- life_lost is high exactly one cycle: the cycle after the MISS tick.
- ball_ON has zero latency from pix_x/pix_y.
- Asserting reset mid-frame or mid-MISS returns all outputs to reset values immediately (asynchronous).
- launch and frame_tick on the same cycle in SERVE: enters PLAY on that tick.

## Structure

- Shared package breakout_pkg holds:
  - the state enum (2 bits);
  - screen constants X_MAX/Y_MAX;
  - BALL_SIZE and PADDLE_Y;
  - the block geometry already used by the column modules.
- Sub-module breakout_ball_axis is instantiated twice (x, y). It contains:
  - the pending-latch pair;
  - direction resolution with low/high wall override;
  - the saturating ±SPEED position update.
- The paddle override and miss detection stay in the top level.

## Test plan

- **Reset/serve:** release reset, 3 ticks with launch=0 → ball stays (316,300); lives=3; game_over=0.
- **Launch and free flight:** launch then 5 ticks → after the 1st tick enters PLAY; 4 further moves each +2 x, −2 y → (324,292).
- **Block bounce:**
  - Set up: in PLAY with dy=−, a one-cycle moveD pulse 10 cycles before a tick.
  - Required: that tick moves y by +2.
  - Repeat with moveU and moveD asserted together: dy inverts.
- **Wall and paddle:**
  - ball_x_l=2, dx=− → next tick dx=+, x=4.
  - ball_y_b=449 with paddle 300..380 covering x → dy=− on that tick.
- **Miss sequence:**
  - Set up: paddle away; ball reaches y_b≥479 → MISS.
  - Required on the next tick: life_lost single pulse, lives=2, ball back at (316,300).
  - Repeat until lives=0: game_over=1 and ball_ON=0 for any pixel.
- **Async reset mid-PLAY:**
  - Stimulus: reset asserted between clock edges.
  - Required: outputs return to reset values without waiting for clk; lives=3; pending flags clear.
